instr_fetch_queue: RTL and testbench

//  Fetch-side initiator for the word-addressed instruction ROM. Holds the PC and drives the
//  ROM byte address. It captures the combinational instruction word, tagged with its PC, into
//  a small FIFO. Decode/dispatch drains the FIFO with a valid/ready handshake.

---
 rtl/instr_fetch_queue.sv | 81 ++++++++
 tb/tb_instr_fetch_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: holds the PC, drives the ROM byte address and captures
// {pc, instruction} into a small registered FIFO drained by a valid/ready consumer.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [63:0]                  imem_address,
    input  logic [31:0]                  imem_instruction,
    input  logic                         redirect_valid,
    input  logic [63:0]                  redirect_pc,
    output logic                         deq_valid,
    input  logic                         deq_ready,
    output logic [31:0]                  deq_instr,
    output logic [63:0]                  deq_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         fetch_halted
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [63:0]   pc;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] occ;
    logic [31:0]   instr_q [DEPTH];
    logic [63:0]   pc_q    [DEPTH];

    logic in_range;
    logic pop;
    logic push;

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign in_range = (pc + 64'd3) < 64'(MEM_SIZE);
    assign pop      = deq_valid & deq_ready;
    assign push     = in_range & ~redirect_valid & ((occ < CW'(DEPTH)) | pop);

    assign imem_address = pc;
    assign count        = occ;
    assign deq_valid    = (occ != '0);
    assign deq_instr    = instr_q[head];
    assign deq_pc       = pc_q[head];
    assign fetch_halted = ~in_range & (occ == '0);

    // NOTE: every register here, storage included, is updated with <= so that the
    // head read for deq_* and the tail write in a full+pop cycle see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc   <= RESET_PC;
            head <= '0;
            tail <= '0;
            occ  <= '0;
            // NOTE: the storage array is reset on purpose so deq_instr/deq_pc read 0
            // after reset; this costs reset fan-out and is not needed for correctness.
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (redirect_valid) begin
            // Flush: any pop this cycle is swallowed along with the rest of the queue.
            pc   <= redirect_pc & ~64'h3;
            head <= tail;
            occ  <= '0;
        end else begin
            if (push) begin
                instr_q[tail] <= imem_instruction;
                pc_q[tail]    <= pc;
                tail          <= tail + PW'(1);
                pc            <= pc + 64'd4;
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            occ <= occ + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_instr_fetch_queue;

    localparam int DEPTH    = 4;
    localparam int MEM_SIZE = 1024;
    localparam int CW       = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [63:0]   imem_address;
    logic [31:0]   imem_instruction;
    logic          redirect_valid;
    logic [63:0]   redirect_pc;
    logic          deq_valid;
    logic          deq_ready;
    logic [31:0]   deq_instr;
    logic [63:0]   deq_pc;
    logic [CW-1:0] count;
    logic          fetch_halted;

    int checks   = 0;
    int failures = 0;

    instr_fetch_queue #(.DEPTH(DEPTH), .MEM_SIZE(MEM_SIZE), .RESET_PC(64'h0)) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .deq_valid        (deq_valid),
        .deq_ready        (deq_ready),
        .deq_instr        (deq_instr),
        .deq_pc           (deq_pc),
        .count            (count),
        .fetch_halted     (fetch_halted)
    );

    always #5 clk = ~clk;

    // ROM contents: word k holds the value k.
    function automatic logic [31:0] rom(input logic [63:0] addr);
        return addr[33:2];
    endfunction

    assign imem_instruction = rom(imem_address);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of {pc, word} plus the fetch PC.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mq[$];
    logic [63:0] m_pc;

    function automatic logic m_in_range();
        return (m_pc + 64'd3) < 64'(MEM_SIZE);
    endfunction

    task automatic compare_model(input string tag);
        check({tag, ".valid"}, 64'(deq_valid), 64'(mq.size() != 0));
        check({tag, ".count"}, 64'(count), 64'(mq.size()));
        check({tag, ".addr"}, imem_address, m_pc);
        check({tag, ".halted"}, 64'(fetch_halted), 64'(!m_in_range() && mq.size() == 0));
        if (mq.size() != 0) begin
            check({tag, ".deq_pc"}, deq_pc, mq[0].pc);
            check({tag, ".deq_instr"}, 64'(deq_instr), 64'(mq[0].instr));
        end
    endtask

    // One clock: decide from the current inputs, advance the model at the edge,
    // then compare on the falling edge.
    task automatic step(input string tag);
        logic do_pop;
        logic do_push;
        do_pop  = (mq.size() != 0) && deq_ready;
        do_push = m_in_range() && !redirect_valid && ((mq.size() < DEPTH) || do_pop);
        @(posedge clk);
        if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc & ~64'h3;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back('{pc: m_pc, instr: rom(m_pc)});
                m_pc = m_pc + 64'd4;
            end
        end
        @(negedge clk);
        compare_model(tag);
    endtask

    typedef struct {
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        logic        ev;
        logic [63:0] epc;
        int          ecount;
        logic [63:0] eaddr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rv, input logic [63:0] rpc, input logic rdy,
                                input logic ev, input logic [63:0] epc, input int ecount,
                                input logic [63:0] eaddr);
        vecs.push_back('{rv: rv, rpc: rpc, rdy: rdy, ev: ev, epc: epc, ecount: ecount, eaddr: eaddr});
    endfunction

    initial begin
        logic [63:0] prev_pc;

        // Streaming with the consumer always ready.
        add(0, 0, 1, 1, 64'h0,  1, 64'h4);
        add(0, 0, 1, 1, 64'h4,  1, 64'h8);
        add(0, 0, 1, 1, 64'h8,  1, 64'hC);
        // Consumer stalls for 10 cycles: fill to DEPTH, then the PC holds.
        add(0, 0, 0, 1, 64'h8,  2, 64'h10);
        add(0, 0, 0, 1, 64'h8,  3, 64'h14);
        add(0, 0, 0, 1, 64'h8,  4, 64'h18);
        for (int i = 0; i < 7; i++) add(0, 0, 0, 1, 64'h8, 4, 64'h18);
        // Consumer resumes: one word per cycle with no bubble.
        add(0, 0, 1, 1, 64'hC,  4, 64'h1C);
        add(0, 0, 1, 1, 64'h10, 4, 64'h20);
        add(0, 0, 1, 1, 64'h14, 4, 64'h24);
        // Redirect while full.
        add(1, 64'h40, 1, 0, 64'h0, 0, 64'h40);
        add(0, 0, 1, 1, 64'h40, 1, 64'h44);
        add(0, 0, 1, 1, 64'h44, 1, 64'h48);
        // Back-to-back redirects, unaligned last target.
        add(1, 64'h80,  0, 0, 64'h0, 0, 64'h80);
        add(1, 64'h103, 0, 0, 64'h0, 0, 64'h100);
        add(0, 0, 0, 1, 64'h100, 1, 64'h104);

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        deq_ready      = 1'b0;
        mq.delete();
        m_pc = 64'h0;
        repeat (2) @(negedge clk);
        check("reset.valid",  64'(deq_valid), 64'h0);
        check("reset.count",  64'(count), 64'h0);
        check("reset.instr",  64'(deq_instr), 64'h0);
        check("reset.pc",     deq_pc, 64'h0);
        check("reset.addr",   imem_address, 64'h0);
        check("reset.halted", 64'(fetch_halted), 64'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            deq_ready      = vecs[i].rdy;
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d.valid", i), 64'(deq_valid), 64'(vecs[i].ev));
            check($sformatf("vec%0d.count", i), 64'(count), 64'(vecs[i].ecount));
            check($sformatf("vec%0d.addr", i), imem_address, vecs[i].eaddr);
            check($sformatf("vec%0d.halted", i), 64'(fetch_halted), 64'h0);
            if (vecs[i].ev) begin
                check($sformatf("vec%0d.deq_pc", i), deq_pc, vecs[i].epc);
                check($sformatf("vec%0d.deq_instr", i), 64'(deq_instr), 64'(vecs[i].epc >> 2));
            end
        end
        redirect_valid = 1'b0;

        // Asynchronous reset in the middle of a cycle with three entries queued.
        deq_ready = 1'b0;
        step("fill_a");
        step("fill_b");
        check("pre_reset.count", 64'(count), 64'h3);
        #2 reset = 1'b1;
        #1;
        check("async_reset.count", 64'(count), 64'h0);
        check("async_reset.valid", 64'(deq_valid), 64'h0);
        check("async_reset.addr",  imem_address, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        m_pc = 64'h0;
        compare_model("post_reset");

        // Fetch up to the top of the ROM, halt, then leave the halt with a redirect.
        deq_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3F6;
        step("hi_redirect");
        redirect_valid = 1'b0;
        check("hi.align", imem_address, 64'h3F4);
        step("hi0");
        check("hi0.deq_pc", deq_pc, 64'h3F4);
        step("hi1");
        check("hi1.deq_pc", deq_pc, 64'h3F8);
        step("hi2");
        check("hi2.deq_pc", deq_pc, 64'h3FC);
        step("hi3");
        check("hi3.halted", 64'(fetch_halted), 64'h1);
        check("hi3.addr",   imem_address, 64'h400);
        check("hi3.valid",  64'(deq_valid), 64'h0);
        step("hi4");
        check("hi4.halted", 64'(fetch_halted), 64'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h10;
        step("unhalt");
        redirect_valid = 1'b0;
        check("unhalt.halted", 64'(fetch_halted), 64'h0);
        step("unhalt1");
        check("unhalt1.deq_pc", deq_pc, 64'h10);

        // Full queue with simultaneous push and pop for 20 cycles.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        deq_ready      = 1'b0;
        step("full_redirect");
        redirect_valid = 1'b0;
        repeat (DEPTH) step("full_fill");
        check("full.count", 64'(count), 64'(DEPTH));
        prev_pc   = deq_pc;
        deq_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step("full_stream");
            check($sformatf("full%0d.count", i), 64'(count), 64'(DEPTH));
            check($sformatf("full%0d.seq", i), deq_pc, prev_pc + 64'd4);
            prev_pc = deq_pc;
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            deq_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 64'($urandom_range(0, 1100));
            step($sformatf("rnd%0d", i));
        end
        redirect_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
